// File: rtl/uart_rx.sv
// 8N1 serial receiver with mid-bit sampling and a valid/ready output.
// Flags framing errors (one-cycle pulse) and overruns (sticky).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  idx;
    logic [2:0]  idx_n;
    logic [7:0]  shreg;
    logic [7:0]  shreg_n;
    logic        load;
    logic        load_n;
    logic        ferr_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        shreg_n = shreg;
        load_n  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n        = '0;
                    shreg_n[idx] = rx_s;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    // Re-arm mid stop bit so a following start edge is caught.
                    if (rx_s) begin
                        state_n = IDLE;
                        load_n  = 1'b1;
                    end else begin
                        state_n = WAIT_IDLE;
                        ferr_n  = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            load      <= load_n;
            frame_err <= ferr_n;
            // A new byte beats a same-edge acceptance of the old one.
            if (load) begin
                data  <= shreg;
                valid <= 1'b1;
                if (valid && !ready) overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
// Expected bytes are queued by stimulus and checked on acceptance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    logic       auto_ack = 1'b0;
    logic       man_ready = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    logic [7:0] sb[$];

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready driver and monitor: a byte is accepted at the next posedge.
    always @(negedge clk) begin
        ready = auto_ack ? valid : man_ready;
        if (valid && ready) begin
            if (sb.size() == 0) begin
                chk("spurious_byte", int'(data), -1);
            end else begin
                chk("byte", int'(data), int'(sb.pop_front()));
            end
        end
        if (frame_err) fe_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 man_ready = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int fe0;
        do_reset();
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);

        // Single byte, held until ready
        sb.push_back(8'hA5);
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                do begin
                    @(negedge clk);
                    lat++;
                end while (!valid && lat < 400);
            end
        join
        chk("latency_ok", int'(lat >= 154 && lat <= 156), 1);
        chk("a5_data", int'(data), 8'hA5);
        chk("a5_valid", int'(valid), 1);
        chk("a5_ferr", fe_cnt, 0);
        chk("a5_ovr", int'(overrun), 0);
        repeat (20) @(negedge clk);
        chk("a5_hold", int'(valid), 1);
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("a5_drop", int'(valid), 0);
        set_ready(1'b0);

        // Back-to-back frames with auto acknowledge
        @(negedge clk);
        auto_ack = 1'b1;
        sb.push_back(8'h3C);
        sb.push_back(8'hC3);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        chk("b2b_sb", sb.size(), 0);
        chk("b2b_ovr", int'(overrun), 0);
        chk("b2b_valid", int'(valid), 0);

        // Overrun: 0x11 is lost, 0x22 remains
        auto_ack = 1'b0;
        sb.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        chk("ovr_valid", int'(valid), 1);
        chk("ovr_data", int'(data), 8'h22);
        chk("ovr_flag", int'(overrun), 1);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        set_ready(1'b0);
        repeat (3) @(negedge clk);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_sb", sb.size(), 0);

        // Framing error followed by a break
        do_reset();
        chk("rst2_ovr", int'(overrun), 0);
        auto_ack = 1'b1;
        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("brk_busy", int'(busy), 1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_pulses", fe_cnt - fe0, 1);
        chk("ferr_valid", int'(valid), 0);
        chk("ferr_idle", int'(busy), 0);
        chk("ferr_sb", sb.size(), 0);
        sb.push_back(8'h7E);
        send_byte(8'h7E, 1'b1);
        repeat (10) @(negedge clk);
        chk("7e_sb", sb.size(), 0);
        chk("7e_ferr", fe_cnt - fe0, 1);

        // Short glitch aborts in START
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", int'(busy), 1);
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_idle", int'(busy), 0);
        chk("glitch_valid", int'(valid), 0);
        chk("glitch_ferr", fe_cnt - fe0, 0);

        // Reset during data bit 4
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (88) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("mid_data", int'(data), 0);
                chk("mid_valid", int'(valid), 0);
                chk("mid_busy", int'(busy), 0);
                chk("mid_ferr", int'(frame_err), 0);
                chk("mid_ovr", int'(overrun), 0);
                rst = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("mid_after", int'(valid), 0);
        sb.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        chk("81_sb", sb.size(), 0);
        chk("81_ovr", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the team's UART transmitter.
- Format: 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit).
- Recovers each byte by mid-bit sampling and hands it to downstream logic over a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit period (50 MHz / 9600 baud); legal range 4..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available; held until accepted.
- ready  input  1  downstream accepts byte when valid&&ready at a rising edge.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; set when a byte completes while valid=1; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clk edge):
  - data=0, valid=0, busy=0, frame_err=0, overrun=0.
  - State=IDLE, counters=0, synchronizer flops=1.
  - Applies mid-frame too: any partial byte is discarded.
- Input synchronization: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, giving 2 cycles of input latency.
- Bit counter: width 16 bits, counts 0..CLKS_PER_BIT-1, reloads to 0 on every state change. Bit index is 3 bits, 0..7.
- IDLE:
  - rx_s=0 -> START, counter cleared.
- START:
  - At counter = CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - rx_s=0 -> DATA, bit index=0.
  - rx_s=1 -> glitch; return to IDLE with no flag.
- DATA:
  - At counter = CLKS_PER_BIT-1, sample rx_s into shift register bit [index]; LSB received first.
  - Index 7 -> STOP; otherwise index+1.
- STOP, at counter = CLKS_PER_BIT-1, sample rx_s:
  - rx_s=1 -> IDLE. On the next edge, data <= shift register and valid <= 1 (valid rises 1 cycle after the stop sample).
  - If valid was already 1 at that point: data is overwritten with the new byte and overrun <= 1.
  - rx_s=0 -> frame_err pulses for exactly 1 cycle; byte discarded; valid/data untouched; go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s=1, then IDLE. This prevents a break condition (line held low) from being decoded as 0x00 bytes.
- Handshake:
  - valid&&ready at an edge -> valid <= 0 on that edge.
  - Same edge as a new byte load: the load wins, valid stays 1, data updates, overrun is not set.
  - ready is ignored while valid=0.
- Re-arm timing: returning to IDLE right after the stop sample (mid stop bit) allows back-to-back frames at full line rate with ±half-bit tolerance.
- Total latency: start-bit falling edge on rx to valid rising ≈ 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1).

Test Plan:
- CLKS_PER_BIT=16. After reset, drive the frame for 0xA5 with ready=0 -> valid rises ~2+8+144+1 cycles after the start edge; data=0xA5; frame_err=0; overrun=0; valid held until ready=1, then drops the following edge.
- Two back-to-back frames 0x3C then 0xC3, with no idle gap and ready=1 asserted one cycle after each valid -> two accepted bytes 0x3C, 0xC3; overrun stays 0.
- Two frames 0x11, 0x22 with ready=0 throughout -> data=0x22, valid=1, overrun=1 (sticky until reset).
- Frame 0x55 with the stop bit driven low, then rx held low for 40 cycles, then high -> one frame_err pulse; valid stays 0; busy held through the low period; no spurious byte; a following 0x7E frame is received correctly.
- rx low pulse of 5 cycles (shorter than the half-bit) from IDLE -> START aborts back to IDLE; no valid, no frame_err.
- rst=0 asserted during DATA bit 4 of a frame -> all outputs 0 next edge; after release with rx idle, the next 0x81 frame is received correctly.
